// File: rtl/bus_map_pkg.sv
// Shared definitions for the CPU bus responder: region codes, I/O offsets,
// FSM encodings and the address-window decoder.
package bus_map_pkg;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_ROM  = 2'd1,
        REG_IO   = 2'd2,
        REG_NONE = 2'd3
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] IO_LED = 4'd0;
    localparam logic [3:0] IO_CNT = 4'd1;
    localparam logic [3:0] IO_SW  = 4'd2;

    localparam logic [7:0] UNMAPPED_DATA_DEFAULT = 8'hEA;

    // RAM sits at the bottom of the map, ROM at the top, I/O is a 16-byte window.
    function automatic region_t decode_region(input logic [15:0] a,
                                              input int          ram_aw,
                                              input int          rom_aw,
                                              input logic [15:0] io_base);
        logic [31:0] a32;
        a32 = {16'h0000, a};
        if (a32 < (32'd1 << ram_aw))
            return REG_RAM;
        else if (a[15:4] == io_base[15:4])
            return REG_IO;
        else if (a32 >= (32'h0001_0000 - (32'd1 << rom_aw)))
            return REG_ROM;
        else
            return REG_NONE;
    endfunction

endpackage

// File: rtl/sync_ram.sv
// Single-port-write, registered-read memory array used for both RAM and ROM.
module sync_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/bus_memory_responder.sv
// Memory-side responder for the cpu_core bus: RAM, wait-stated ROM, a small
// I/O block (LEDs, switches, cycle counter) and a loader port for RAM/ROM.
module bus_memory_responder
    import bus_map_pkg::*;
#(
    parameter int          RAM_AW        = 11,
    parameter int          ROM_AW        = 12,
    parameter int          ROM_WS        = 2,
    parameter logic [15:0] IO_BASE       = 16'hD000,
    parameter logic [7:0]  UNMAPPED_DATA = UNMAPPED_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ready,
    input  logic        prog_we,
    input  logic [15:0] prog_addr,
    input  logic [7:0]  prog_data,
    input  logic [7:0]  sw_in,
    output logic [7:0]  led_out
);

    state_t      state;
    logic [2:0]  ws_cnt;
    logic [7:0]  cycle_cnt;

    logic [15:0] addr_p0;
    logic        we_p0;
    logic [7:0]  wdata_p0;
    region_t     region_p0;

    region_t     req_region;
    region_t     prog_region;
    logic        accept;
    logic        commit;
    logic        prog_ram_we;
    logic        prog_rom_we;
    logic        cpu_ram_we;
    logic        ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [RAM_AW-1:0] ram_raddr;
    logic [7:0]  ram_wdata;
    logic [ROM_AW-1:0] rom_raddr;
    logic [7:0]  ram_q;
    logic [7:0]  rom_q;
    logic [7:0]  read_mux;

    assign req_region  = decode_region(addr, RAM_AW, ROM_AW, IO_BASE);
    assign prog_region = decode_region(prog_addr, RAM_AW, ROM_AW, IO_BASE);

    assign accept = (state == ST_IDLE) && req && !prog_we;
    assign commit = (state == ST_WAIT) && (ws_cnt == 3'd0);

    // Loader owns the RAM write port when it targets RAM; a colliding CPU write is dropped.
    assign prog_ram_we = prog_we && (prog_region == REG_RAM);
    assign prog_rom_we = prog_we && (prog_region == REG_ROM);
    assign cpu_ram_we  = commit && we_p0 && (region_p0 == REG_RAM) && !reset;
    assign ram_we      = prog_ram_we || cpu_ram_we;
    assign ram_waddr   = prog_ram_we ? prog_addr[RAM_AW-1:0] : addr_p0[RAM_AW-1:0];
    assign ram_wdata   = prog_ram_we ? prog_data : wdata_p0;

    // Reading the live address in IDLE makes array data ready by the first WAIT edge.
    assign ram_raddr = (state == ST_IDLE) ? addr[RAM_AW-1:0] : addr_p0[RAM_AW-1:0];
    assign rom_raddr = (state == ST_IDLE) ? addr[ROM_AW-1:0] : addr_p0[ROM_AW-1:0];

    sync_ram #(.DATA_W(8), .ADDR_W(RAM_AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    sync_ram #(.DATA_W(8), .ADDR_W(ROM_AW)) u_rom (
        .clk   (clk),
        .we    (prog_rom_we),
        .waddr (prog_addr[ROM_AW-1:0]),
        .wdata (prog_data),
        .raddr (rom_raddr),
        .rdata (rom_q)
    );

    always_comb begin
        read_mux = UNMAPPED_DATA;
        case (region_p0)
            REG_RAM: read_mux = ram_q;
            REG_ROM: read_mux = rom_q;
            REG_IO: begin
                case (addr_p0[3:0])
                    IO_LED:  read_mux = led_out;
                    IO_CNT:  read_mux = cycle_cnt;
                    IO_SW:   read_mux = sw_in;
                    default: read_mux = 8'h00;
                endcase
            end
            default: read_mux = UNMAPPED_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            cycle_cnt <= 8'd0;
        else
            cycle_cnt <= cycle_cnt + 8'd1;
    end

    // Request capture (p0): held for the whole access, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0   <= addr;
            we_p0     <= we;
            wdata_p0  <= wdata;
            region_p0 <= req_region;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ws_cnt  <= 3'd0;
            ready   <= 1'b0;
            rdata   <= 8'd0;
            led_out <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready <= 1'b0;
                    if (accept) begin
                        ws_cnt <= (req_region == REG_ROM) ? 3'(ROM_WS) : 3'd0;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ws_cnt != 3'd0) begin
                        ws_cnt <= ws_cnt - 3'd1;
                    end else begin
                        ready <= 1'b1;
                        state <= ST_RESP;
                        if (!we_p0)
                            rdata <= read_mux;
                        else if (region_p0 == REG_IO && addr_p0[3:0] == IO_LED)
                            led_out <= wdata_p0;
                    end
                end
                default: begin
                    ready <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_memory_responder.sv
// Randomised self-checking bench for bus_memory_responder with a behavioural memory map model.
module tb_bus_memory_responder;

    localparam int ROM_WS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ready;
    logic        prog_we;
    logic [15:0] prog_addr;
    logic [7:0]  prog_data;
    logic [7:0]  sw_in;
    logic [7:0]  led_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram_m [2048];
    logic [7:0] rom_m [4096];
    logic [15:0] rom_loaded [$];
    logic [7:0] last_rd;

    always #5 clk = ~clk;

    bus_memory_responder #(
        .RAM_AW(11), .ROM_AW(12), .ROM_WS(ROM_WS),
        .IO_BASE(16'hD000), .UNMAPPED_DATA(8'hEA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .addr      (addr),
        .we        (we),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .sw_in     (sw_in),
        .led_out   (led_out)
    );

    // Memory-map reference: expected read data for RAM, ROM, unmapped and spare I/O offsets.
    function automatic logic [7:0] model_read(input logic [15:0] a);
        if (a < 16'h0800)               return ram_m[a % 2048];
        if (a >= 16'hD000 && a <= 16'hD00F) return 8'h00;
        if (a >= 16'hF000)              return rom_m[a - 16'hF000];
        return 8'hEA;
    endfunction

    function automatic int model_latency(input logic [15:0] a);
        return (a >= 16'hF000) ? 2 + ROM_WS : 2;
    endfunction

    task automatic load(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
    endtask

    // One CPU access; lat counts negedges after the sampling edge until ready is seen.
    task automatic do_access(input logic [15:0] a, input logic w, input logic [7:0] d,
                             output logic [7:0] rd, output int lat);
        @(negedge clk);
        req = 1'b1; addr = a; we = w; wdata = d;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                lat = n;
                break;
            end
        end
        rd  = rdata;
        req = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", rdata); end
        checks++; if (ready !== 1'b0)  begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++; if (led_out !== 8'h00) begin errors++; $display("FAIL reset_led got %h want 00", led_out); end
    endtask

    task automatic test_rom_read;
        logic [7:0] rd; int lat;
        do_access(16'hFFFC, 1'b0, 8'h00, rd, lat);
        checks++; if (lat !== 2 + ROM_WS) begin errors++; $display("FAIL rom_latency got %0d want %0d", lat, 2 + ROM_WS); end
        checks++; if (rd !== 8'h34) begin errors++; $display("FAIL rom_read_fffc got %h want 34", rd); end
        do_access(16'hFFFF, 1'b0, 8'h00, rd, lat);
        checks++; if (rd !== rom_m[12'hFFF]) begin errors++; $display("FAIL rom_read_ffff got %h want %h", rd, rom_m[12'hFFF]); end
        last_rd = rd;
    endtask

    task automatic test_ram_rw;
        logic [7:0] rd; int lat;
        do_access(16'h0010, 1'b1, 8'h5A, rd, lat);
        ram_m[16'h0010] = 8'h5A;
        checks++; if (lat !== 2) begin errors++; $display("FAIL ram_write_latency got %0d want 2", lat); end
        checks++; if (rd !== last_rd) begin errors++; $display("FAIL ram_write_rdata_held got %h want %h", rd, last_rd); end
        do_access(16'h0010, 1'b0, 8'h00, rd, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL ram_read_latency got %0d want 2", lat); end
        checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL ram_read_0010 got %h want 5a", rd); end
        do_access(16'h0810, 1'b0, 8'h00, rd, lat);
        checks++; if (rd !== 8'hEA) begin errors++; $display("FAIL unmapped_0810 got %h want ea", rd); end
        last_rd = rd;
    endtask

    task automatic test_rom_write_ignored;
        logic [7:0] rd; int lat;
        do_access(16'hF000, 1'b1, 8'h99, rd, lat);
        checks++; if (lat !== 2 + ROM_WS) begin errors++; $display("FAIL rom_write_ready got %0d want %0d", lat, 2 + ROM_WS); end
        do_access(16'hF000, 1'b0, 8'h00, rd, lat);
        checks++; if (rd !== 8'h11) begin errors++; $display("FAIL rom_write_ignored got %h want 11", rd); end
        last_rd = rd;
    endtask

    task automatic test_io;
        logic [7:0] rd; logic [7:0] c1; int lat;
        do_access(16'hD000, 1'b1, 8'hA5, rd, lat);
        checks++; if (led_out !== 8'hA5) begin errors++; $display("FAIL io_led_write got %h want a5", led_out); end
        do_access(16'hD000, 1'b0, 8'h00, rd, lat);
        checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL io_led_read got %h want a5", rd); end
        sw_in = 8'h3C;
        do_access(16'hD002, 1'b0, 8'h00, rd, lat);
        checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL io_sw_read got %h want 3c", rd); end
        do_access(16'hD001, 1'b0, 8'h00, c1, lat);
        // Second sampling edge lands exactly ten clocks after the first.
        repeat (7) @(negedge clk);
        do_access(16'hD001, 1'b0, 8'h00, rd, lat);
        checks++; if (rd !== c1 + 8'd10) begin errors++; $display("FAIL io_cycle_cnt_delta got %h want %h", rd, c1 + 8'd10); end
        last_rd = rd;
    endtask

    task automatic test_loader_priority;
        logic [7:0] nv; int lat;
        nv = 8'($urandom);
        @(negedge clk);
        req = 1'b1; addr = 16'h0030; we = 1'b0; wdata = 8'h00;
        prog_we = 1'b1; prog_addr = 16'h0030; prog_data = nv;
        ram_m[16'h0030] = nv;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL loader_priority_ready cycle %0d got %b want 0", n, ready); end
        end
        prog_we = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ready === 1'b1) begin lat = n; break; end
        end
        req = 1'b0;
        checks++; if (lat !== 2) begin errors++; $display("FAIL loader_release_latency got %0d want 2", lat); end
        checks++; if (rdata !== nv) begin errors++; $display("FAIL loader_release_rdata got %h want %h", rdata, nv); end
        last_rd = rdata;
    endtask

    task automatic test_reset_abort;
        logic [7:0] rd; int lat;
        @(negedge clk);
        req = 1'b1; addr = 16'h0020; we = 1'b1; wdata = 8'h77;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1; req = 1'b0; we = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_ready cycle %0d got %b want 0", n, ready); end
        end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL abort_rdata got %h want 00", rdata); end
        checks++; if (led_out !== 8'h00) begin errors++; $display("FAIL abort_led got %h want 00", led_out); end
        reset = 1'b0;
        do_access(16'h0020, 1'b0, 8'h00, rd, lat);
        checks++; if (rd !== ram_m[16'h0020]) begin errors++; $display("FAIL abort_write_discarded got %h want %h", rd, ram_m[16'h0020]); end
        last_rd = rd;
    endtask

    task automatic test_random;
        logic [7:0] rd; logic [7:0] d; logic [15:0] a; int lat; int kind; logic w;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 5);
            d = 8'($urandom);
            w = 1'b0;
            case (kind)
                0: a = 16'($urandom_range(0, 63));
                1: begin a = 16'($urandom_range(0, 63)); w = 1'b1; end
                2: a = rom_loaded[$urandom_range(0, rom_loaded.size() - 1)];
                3: a = 16'($urandom_range(16'h0800, 16'hCFFF));
                4: a = 16'hD000 + 16'($urandom_range(3, 15));
                default: begin a = 16'($urandom_range(16'h0800, 16'hCFFF)); w = 1'b1; end
            endcase
            do_access(a, w, d, rd, lat);
            checks++;
            if (lat !== model_latency(a)) begin
                errors++; $display("FAIL rand_latency addr %h got %0d want %0d", a, lat, model_latency(a));
            end
            if (w) begin
                checks++;
                if (rd !== last_rd) begin errors++; $display("FAIL rand_write_rdata_held addr %h got %h want %h", a, rd, last_rd); end
                if (a < 16'h0800) ram_m[a] = d;
            end else begin
                checks++;
                if (rd !== model_read(a)) begin errors++; $display("FAIL rand_read addr %h got %h want %h", a, rd, model_read(a)); end
                last_rd = model_read(a);
            end
        end
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; addr = 16'h0000; we = 1'b0; wdata = 8'h00;
        prog_we = 1'b0; prog_addr = 16'h0000; prog_data = 8'h00; sw_in = 8'h00;
        last_rd = 8'h00;
        for (int i = 0; i < 2048; i++) ram_m[i] = 8'h00;
        for (int i = 0; i < 4096; i++) rom_m[i] = 8'h00;
        repeat (3) @(posedge clk);
        test_reset;

        // Loader fill while held in reset.
        for (int i = 0; i < 64; i++) begin
            ram_m[i] = 8'($urandom);
            load(16'(i), ram_m[i]);
        end
        load(16'hFFFC, 8'h34); rom_m[12'hFFC] = 8'h34; rom_loaded.push_back(16'hFFFC);
        load(16'hFFFD, 8'h12); rom_m[12'hFFD] = 8'h12; rom_loaded.push_back(16'hFFFD);
        load(16'hF000, 8'h11); rom_m[12'h000] = 8'h11; rom_loaded.push_back(16'hF000);
        for (int i = 0; i < 16; i++) begin
            logic [15:0] ra;
            ra = 16'hFFE0 + 16'(i);
            if (ra != 16'hFFFC && ra != 16'hFFFD) begin
                rom_m[ra - 16'hF000] = 8'($urandom);
                load(ra, rom_m[ra - 16'hF000]);
                rom_loaded.push_back(ra);
            end
        end
        rom_m[12'hFFF] = 8'h5C; load(16'hFFFF, 8'h5C); rom_loaded.push_back(16'hFFFF);
        load(16'hD003, 8'hFF);
        @(negedge clk);
        prog_we = 1'b0;
        reset = 1'b0;

        test_rom_read;
        test_ram_rw;
        test_rom_write_ignored;
        test_io;
        test_loader_priority;
        test_reset_abort;
        test_random;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
